// File: rtl/load_ext_ctrl_if.sv
// load_ext_ctrl_if: load request/response and data-memory read signals of load_ext_ctrl.
interface load_ext_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [31:0] data_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    modport slave (
        input  start, op, addr, mem_rdata, mem_ready,
        output busy, done, err, data_out, mem_req, mem_addr
    );
    modport master (
        output start, op, addr, mem_rdata, mem_ready,
        input  busy, done, err, data_out, mem_req, mem_addr
    );
endinterface

// File: rtl/load_ext_ctrl.sv
// load_ext_ctrl: single-outstanding load unit; fetches an aligned word, then
// selects and sign/zero-extends the byte/half lane, with misalign/illegal/timeout errors.
module load_ext_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst_n,
    load_ext_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_EXT  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  err_q, err_d;
    logic        illegal, misaligned, sx;
    logic [7:0]  byte_l;
    logic [15:0] half_l;
    logic [31:0] ext;

    always_comb begin
        illegal    = bus.op == 3'b010 || bus.op[2:1] == 2'b11;
        misaligned = (bus.op[1:0] == 2'b01 && bus.addr[0]) ||
                     (bus.op[1:0] == 2'b11 && bus.addr[1:0] != 2'b00);
        byte_l     = 8'(rdata_q >> {addr_q[1:0], 3'b000});
        half_l     = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        sx         = ~op_q[2];
        ext        = op_q[1:0] == 2'b00 ? {{24{sx & byte_l[7]}}, byte_l} :
                     op_q[1:0] == 2'b01 ? {{16{sx & half_l[15]}}, half_l} : rdata_q;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                op_d    = bus.op;
                addr_d  = bus.addr;
                cnt_d   = 8'd0;
                err_d   = illegal ? 2'b10 : 2'b01;
                state_d = (illegal || misaligned) ? S_ERR : S_REQ;
            end
            // ready beats the timeout when both land in the same cycle
            S_REQ: if (bus.mem_ready) begin
                rdata_d = bus.mem_rdata;
                state_d = S_EXT;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                err_d   = 2'b11;
                state_d = S_ERR;
            end else begin
                cnt_d   = cnt_q + 8'd1;
            end
            S_EXT: begin
                data_d  = ext;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.mem_req  = state_q == S_REQ;
    assign bus.mem_addr = {addr_q[31:2], 2'b00};
    assign bus.busy     = state_q != S_IDLE;
    assign bus.done     = state_q == S_DONE || state_q == S_ERR;
    assign bus.err      = state_q == S_ERR ? err_q : 2'b00;
    assign bus.data_out = data_q;
endmodule

// File: tb/tb_load_ext_ctrl.sv
// tb_load_ext_ctrl: random loads against a lane-arithmetic reference model, with a
// queue-based scoreboard checked whenever done pulses.
module tb_load_ext_ctrl;
    localparam int TO = 16;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
        int          lat;
        int          reqc;
        int          issue;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    load_ext_ctrl_if bus ();
    load_ext_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int          n_vec = 0, n_err = 0, cyc = 0, req_cyc = 0, rc = 0, cur_delay = 0;
    logic [31:0] cur_word = 0, exp_maddr = 0, last_data = 0;
    exp_t        q[$];
    exp_t        mon_e;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic exp_t model(logic [2:0] o, logic [31:0] a, logic [31:0] w, int d);
        exp_t        e;
        logic [31:0] b, h;
        e.data = 0; e.err = 0; e.lat = 1; e.reqc = 0; e.issue = 0;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
        if (!(o inside {3'b000, 3'b100, 3'b001, 3'b101, 3'b011})) e.err = 2;
        else if ((o[1:0] == 2'b01 && a % 2 != 0) || (o == 3'b011 && a % 4 != 0)) e.err = 1;
        else if (d >= TO) begin e.err = 3; e.lat = TO + 1; e.reqc = TO; end
        else begin
            e.lat = d + 3; e.reqc = d + 1;
            case (o)
                3'b000:  e.data = b >= 128 ? b + 32'hFFFFFF00 : b;
                3'b100:  e.data = b;
                3'b001:  e.data = h >= 32768 ? h + 32'hFFFF0000 : h;
                3'b101:  e.data = h;
                default: e.data = w;
            endcase
        end
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // memory responder: ready after cur_delay REQ cycles, noise on ready outside REQ
    always @(negedge clk) begin
        if (!rst_n) begin
            rc = 0;
            bus.mem_ready = 0;
        end else if (bus.mem_req) begin
            if (rc == 0) chk("mem_addr", bus.mem_addr, exp_maddr);
            bus.mem_ready = (rc == cur_delay);
            bus.mem_rdata = bus.mem_ready ? cur_word : $urandom;
            rc++;
            req_cyc++;
        end else begin
            rc = 0;
            bus.mem_ready = 1'($urandom % 2);
            bus.mem_rdata = $urandom;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL spurious_done: got done=1 expected no pending load (cycle %0d)", cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("data_out", bus.data_out, mon_e.data);
                    chk("err", {30'b0, bus.err}, {30'b0, mon_e.err});
                    chk("latency", cyc - mon_e.issue, mon_e.lat);
                    chk("mem_req_cycles", req_cyc, mon_e.reqc);
                    req_cyc = 0;
                end
            end else chk("err_without_done", {30'b0, bus.err}, 0);
        end
    end

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w, input int d);
        exp_t e;
        int   n;
        e = model(o, a, w, d);
        if (e.err == 0) last_data = e.data;
        e.data = last_data;
        e.issue = cyc;
        cur_delay = d; cur_word = w; exp_maddr = {a[31:2], 2'b00};
        q.push_back(e);
        bus.start = 1; bus.op = o; bus.addr = a;
        @(negedge clk);
        n = 0;
        // hammer start while busy; none of these may be accepted
        while (!bus.done && n < 300) begin
            bus.start = 1'($urandom % 2); bus.op = 3'($urandom); bus.addr = $urandom;
            @(negedge clk);
            n++;
        end
        bus.start = 0;
        if (n >= 300) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("busy_fall", {31'b0, bus.busy}, 0);
    endtask

    initial begin
        bus.start = 0; bus.op = 0; bus.addr = 0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", {31'b0, bus.mem_req}, 0);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_done", {31'b0, bus.done}, 0);
        chk("rst_err", {30'b0, bus.err}, 0);
        chk("rst_data_out", bus.data_out, 0);
        rst_n = 1;
        @(negedge clk);
        run(3'b000, 32'h1003, 32'h80123456, 0);
        run(3'b100, 32'h1003, 32'h80123456, 0);
        run(3'b101, 32'h1002, 32'h80123456, 0);
        run(3'b001, 32'h1002, 32'h80123456, 0);
        run(3'b001, 32'h1001, 32'h80123456, 0);
        run(3'b010, 32'h1000, 32'h80123456, 0);
        run(3'b011, 32'h2000, 32'hCAFEF00D, 99);
        run(3'b011, 32'h2000, 32'hCAFEF00D, TO - 1);
        run(3'b011, 32'h2002, 32'h12345678, 0);
        run(3'b111, 32'h2003, 32'h12345678, 0);
        run(3'b100, 32'h2001, 32'h0000FF00, 4);
        // reset in the middle of REQ: no done, outputs drop at once
        cur_delay = 1000; cur_word = $urandom; exp_maddr = 32'h3000;
        bus.op = 3'b011; bus.addr = 32'h3000; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        repeat (3) @(negedge clk);
        chk("req_before_rst", {31'b0, bus.mem_req}, 1);
        rst_n = 0;
        #1;
        chk("async_rst_mem_req", {31'b0, bus.mem_req}, 0);
        chk("async_rst_busy", {31'b0, bus.busy}, 0);
        chk("async_rst_data_out", bus.data_out, 0);
        last_data = 0; req_cyc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        run(3'b001, 32'h1002, 32'h80123456, 0);
        for (int i = 0; i < 200; i++)
            run(3'($urandom_range(0, 7)), $urandom, $urandom, int'($urandom_range(0, 19)));
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
